// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: cache/pmem bus bundle for the memory port arbiter
//   slave  : arbiter view (cache requests and pmem response in, responses and pmem command out)
//   master : environment view (caches plus cacheline adaptor)
//   i_*    : I-cache read request, line address, returned line, done pulse
//   d_*    : D-cache read/writeback request, line address, writeback line, returned line, done pulse
//   pm_*   : pmem read/write command, registered address and write line, read line, done
//   grant_o: current owner, 00 none, 01 I, 10 D
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [LINE_W-1:0] i_rdata_o;
    logic              i_resp_o;
    logic              d_read_i;
    logic              d_write_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [LINE_W-1:0] d_wdata_i;
    logic [LINE_W-1:0] d_rdata_o;
    logic              d_resp_o;
    logic              pm_read_o;
    logic              pm_write_o;
    logic [ADDR_W-1:0] pm_addr_o;
    logic [LINE_W-1:0] pm_wdata_o;
    logic [LINE_W-1:0] pm_rdata_i;
    logic              pm_resp_i;
    logic [1:0]        grant_o;

    modport slave (
        input  i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i, pm_rdata_i, pm_resp_i,
        output i_rdata_o, i_resp_o, d_rdata_o, d_resp_o, pm_read_o, pm_write_o, pm_addr_o, pm_wdata_o, grant_o
    );

    modport master (
        output i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i, pm_rdata_i, pm_resp_i,
        input  i_rdata_o, i_resp_o, d_rdata_o, d_resp_o, pm_read_o, pm_write_o, pm_addr_o, pm_wdata_o, grant_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single pmem cacheline port between the I-cache and D-cache
//   clk : clock
//   rst : asynchronous active-high reset, abandons any in-flight transaction
//   bus : mem_port_arbiter_if.slave bundle (cache requests/responses, pmem command/response, grant_o)
// Default arbitration is D-priority with the I-cache forced in after STARVE_LIMIT consecutive
// D grants made while I waits. Defining ARB_ROUND_ROBIN_EN switches contested grants to
// round robin instead and drops the starve counter.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_owner_d;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              w_d_req;
    logic              w_force_i;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_serve;

    assign w_d_req   = bus.d_read_i | bus.d_write_i;
    assign w_serve   = (r_state == SERVE_I) || (r_state == SERVE_D);
    // I wins whenever D is absent, and also when the contest is decided in its favour
    assign w_grant_i = (r_state == IDLE) && bus.i_read_i && (!w_d_req || w_force_i);
    assign w_grant_d = (r_state == IDLE) && w_d_req && !w_grant_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;

    assign w_force_i = r_last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_d <= 1'b0;
        else if (w_grant_i || w_grant_d)
            r_last_d <= w_grant_d;
    end
`else
    logic [3:0] r_starve;

    assign w_force_i = (r_starve == 4'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_starve <= '0;
        else if (w_grant_i)
            r_starve <= '0;
        else if (w_grant_d && bus.i_read_i && !w_force_i)
            r_starve <= r_starve + 4'd1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = w_grant_i                 ? SERVE_I :
                 w_grant_d                 ? SERVE_D :
                 (w_serve && bus.pm_resp_i) ? DONE    :
                 (r_state == DONE)         ? IDLE    : r_state;
        // commands come straight from state so reset drops them without waiting for a clock
        bus.pm_read_o  = w_serve && !r_write;
        bus.pm_write_o = w_serve && r_write;
        bus.grant_o    = (r_state == IDLE) ? 2'b00 : r_owner_d ? 2'b10 : 2'b01;
        bus.i_resp_o   = (r_state == DONE) && !r_owner_d;
        bus.d_resp_o   = (r_state == DONE) && r_owner_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_d <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_grant_i || w_grant_d) begin
                r_owner_d <= w_grant_d;
                // read and write together is treated as a writeback
                r_write   <= w_grant_d && bus.d_write_i;
                r_addr    <= w_grant_d ? bus.d_addr_i : bus.i_addr_i;
            end
            if (w_grant_d)
                r_wdata <= bus.d_wdata_i;
            if (w_serve && bus.pm_resp_i && !r_write && !r_owner_d)
                r_i_rdata <= bus.pm_rdata_i;
            if (w_serve && bus.pm_resp_i && !r_write && r_owner_d)
                r_d_rdata <= bus.pm_rdata_i;
        end
    end

    assign bus.pm_addr_o  = r_addr;
    assign bus.pm_wdata_o = r_wdata;
    assign bus.i_rdata_o  = r_i_rdata;
    assign bus.d_rdata_o  = r_d_rdata;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical-memory cacheline port between the I-cache and the D-cache miss/writeback paths.
- Sits between both caches and the cacheline adaptor.
- Registers the winner's address and write data, holds them stable for the whole pmem transaction, and returns a one-cycle response to the granted cache only.
- The pipeline stall logic consumes the resulting cache resp signals.

Parameters:
- ADDR_W, 32, physical address width.
- LINE_W, 256, cacheline data width.
- STARVE_LIMIT, 4, max consecutive D grants issued while I is waiting before I is forced (legal range 1..15).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- i_read_i  input  1  I-cache line read request, level, held until i_resp_o.
- i_addr_i  input  ADDR_W  I-cache line address.
- i_rdata_o  output  LINE_W  I-cache returned line.
- i_resp_o  output  1  I-cache transaction done, one-cycle pulse.
- d_read_i  input  1  D-cache line read request, level.
- d_write_i  input  1  D-cache line writeback request, level.
- d_addr_i  input  ADDR_W  D-cache line address.
- d_wdata_i  input  LINE_W  D-cache writeback line.
- d_rdata_o  output  LINE_W  D-cache returned line.
- d_resp_o  output  1  D-cache transaction done, one-cycle pulse.
- pm_read_o  output  1  pmem read command.
- pm_write_o  output  1  pmem write command.
- pm_addr_o  output  ADDR_W  pmem address (registered).
- pm_wdata_o  output  LINE_W  pmem write line (registered).
- pm_rdata_i  input  LINE_W  pmem read line.
- pm_resp_i  input  1  pmem done.
- grant_o  output  2  current owner: 00 none, 01 I, 10 D.

Behaviour:
- Reset: all outputs 0; state IDLE; starve counter 0; last-grant flop = I.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: sample requests; d_req = d_read_i | d_write_i.
  - None pending: stay in IDLE.
  - Only one requester pending: grant it.
  - Both pending: grant D, unless starve counter == STARVE_LIMIT, in which case grant I.
  - On grant, latch addr, wdata, and op (I is always read; D is write if d_write_i else read).
  - d_read_i and d_write_i both high is illegal; it is treated as a write.
- SERVE_x: pm_read_o/pm_write_o are held high from the cycle after grant until pm_resp_i.
  - pm_addr_o/pm_wdata_o stay at the latched values; requester inputs are ignored.
  - On pm_resp_i: latch pm_rdata_i into the owner's rdata register (read only); drop the pm command the next cycle; go to DONE.
- DONE (1 cycle): owner's resp_o = 1; grant_o still shows the owner; next state is IDLE.
  - The requester must deassert or change its request by the cycle after resp_o.
  - IDLE re-arbitrates that cycle, so the minimum gap between two pmem commands is 2 cycles.
- Latency:
  - Request seen in IDLE at cycle N gives a pm command at N+1.
  - pm_resp_i at cycle M gives resp_o at M+1 and IDLE at M+2.
- rdata outputs hold their last latched line until overwritten. They are not cleared on resp.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each D grant made while i_read_i=1.
  - Clears on any I grant.
  - Unchanged on a D grant made with no I pending.
- pm_resp_i in IDLE or DONE is ignored.
- Reset mid-transaction: immediate return to IDLE, pm commands drop asynchronously, and the in-flight transaction is abandoned with no resp generated.

Optional Feature:
- ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are pending in IDLE, grant the one that did not win the previous grant (last-grant flop updates on every grant). The starve counter is not implemented and STARVE_LIMIT is unused. Single-requester behaviour is unchanged.
- Undefined: D-priority with the STARVE_LIMIT forcing described above.

Test Plan:
- Lone I read: addr 0x0000_0040; pm_resp 5 cycles after pm_read_o, rdata 0xA5..A5 -> pm_read_o at N+1, i_resp_o one pulse at M+1 with i_rdata_o=0xA5..A5, d_resp_o stays 0, grant_o=01 through DONE.
- Simultaneous I read 0x100 and D write 0x200 (feature off) -> D served first (pm_write_o, pm_addr_o=0x200, pm_wdata_o=d_wdata_i), then I (pm_read_o, pm_addr_o=0x100).
- Starvation, STARVE_LIMIT=4, I held high and D re-requesting continuously -> exactly 4 D grants, then an I grant, then the counter clears to 0.
- d_addr_i changed mid-SERVE_D, 0x200->0x300 -> pm_addr_o stays 0x200 until DONE.
- rst asserted during SERVE_I, then a later pm_resp_i pulse -> pm_read_o=0 asynchronously, no i_resp_o, FSM stays in IDLE.
- ARB_ROUND_ROBIN_EN defined, both continuously pending -> grants alternate D, I, D, I starting with D.
